// File: rtl/multicycle_data_path.sv
// Multi-cycle datapath: fetch, decode, execute, memory and write-back share one
// req/ready memory port; control comes from an external decoder watching instr.
module multicycle_data_path #(
   parameter int WIDTH      = 22,
   parameter int REG_COUNT  = 16,
   parameter int REG_ADDR_W = 4,
   parameter int PC_STEP    = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [WIDTH-1:0]      mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ready,
   output logic [WIDTH-1:0]      instr,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_ADDR_W-1:0] rn_addr,
   input  logic [REG_ADDR_W-1:0] rm_addr,
   input  logic [WIDTH-1:0]      imm_ext,
   input  logic [1:0]            alu_control,
   input  logic                  alu_src,
   input  logic                  mov_src,
   input  logic                  cond_pass,
   input  logic                  set_flags,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic                  is_branch,
   input  logic                  reg_write,
   output logic [WIDTH-1:0]      pc,
   output logic [3:0]            flags,
   output logic [2:0]            state,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(REG_COUNT - 1);
   localparam logic [WIDTH-1:0]      STEP   = WIDTH'(PC_STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, instr_q, a_q, b_q, r_q, ld_q;
   logic [WIDTH-1:0] regs [REG_COUNT];
   logic [3:0]       flags_q;
   logic             fetch_armed_q;

   // pc_q already points past the fetched word, so one more step gives fetch+2*step
   logic [WIDTH-1:0] pc_alias, rn_val, rm_val, rd_val, wb_val;
   assign pc_alias = pc_q + STEP;
   assign rn_val   = (rn_addr == PC_IDX) ? pc_alias : regs[rn_addr];
   assign rm_val   = (rm_addr == PC_IDX) ? pc_alias : regs[rm_addr];
   assign rd_val   = (rd_addr == PC_IDX) ? pc_alias : regs[rd_addr];
   assign wb_val   = is_load ? ld_q : r_q;

   logic [WIDTH-1:0] op_a, alu_r;
   logic [WIDTH:0]   add_full, sub_full;
   logic             alu_c, alu_v, add_v, sub_v;

   assign op_a     = mov_src ? '0 : a_q;
   assign add_full = {1'b0, op_a} + {1'b0, b_q};
   assign sub_full = {1'b0, op_a} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
   assign add_v    = (op_a[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != op_a[WIDTH-1]);
   assign sub_v    = (op_a[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != op_a[WIDTH-1]);

   always_comb begin
      alu_r = add_full[WIDTH-1:0];
      alu_c = flags_q[1];
      alu_v = flags_q[0];
      case (alu_control)
         2'b00: begin alu_r = add_full[WIDTH-1:0]; alu_c = add_full[WIDTH]; alu_v = add_v; end
         2'b01: begin alu_r = sub_full[WIDTH-1:0]; alu_c = sub_full[WIDTH]; alu_v = sub_v; end
         2'b10: alu_r = op_a & b_q;
         default: alu_r = op_a | b_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = rd_val;
      case (state_q)
         S_FETCH: begin
            mem_req = fetch_armed_q;
            if (fetch_armed_q && mem_ready) state_d = S_DECODE;
         end
         S_DECODE: state_d = cond_pass ? S_EXEC : S_FETCH;
         S_EXEC: begin
            if (is_branch)                state_d = S_FETCH;
            else if (is_load || is_store) state_d = S_MEM;
            else if (reg_write)           state_d = S_WB;
            else                          state_d = S_FETCH;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = r_q;
            if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // The very first FETCH cycle after reset is idle so mem_req is low while rst is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= WIDTH'(RESET_PC);
         instr_q       <= '0;
         flags_q       <= '0;
         fetch_armed_q <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         r_q           <= '0;
         ld_q          <= '0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         fetch_armed_q <= 1'b1;
         state_q       <= state_d;
         case (state_q)
            S_FETCH: begin
               if (fetch_armed_q && mem_ready) begin
                  instr_q <= mem_rdata;
                  pc_q    <= pc_q + STEP;
               end
            end
            S_DECODE: begin
               a_q <= rn_val;
               b_q <= alu_src ? imm_ext : rm_val;
            end
            S_EXEC: begin
               r_q <= alu_r;
               if (set_flags) flags_q <= {alu_r[WIDTH-1], (alu_r == '0), alu_c, alu_v};
               if (is_branch) pc_q <= alu_r;
            end
            S_MEM: begin
               if (mem_ready && is_load) ld_q <= mem_rdata;
            end
            S_WB: begin
               regs[rd_addr] <= wb_val;
               if (rd_addr == PC_IDX) pc_q <= wb_val;
            end
            default: ;
         endcase
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign flags = flags_q;
   assign state = state_q;
   assign busy  = !((state_q == S_FETCH) && !fetch_armed_q);

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench: instruction table with hand-computed results, plus reset,
// r15/branch and 8-bit overflow sequences. Register contents are observed via stores.
module tb_multicycle_data_path;

   localparam int W = 22;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_OP = 2'b10, ORR = 2'b11;
   localparam logic [7:0] ASRC = 8'h80, MOV = 8'h40, COND = 8'h20, SETF = 8'h10;
   localparam logic [7:0] LD = 8'h08, ST = 8'h04, BR = 8'h02, RW = 8'h01;
   localparam logic [7:0] STO = ASRC | MOV | COND | ST;
   localparam logic [7:0] LDO = ASRC | MOV | COND | LD | RW;

   typedef struct {
      logic [3:0]   rd, rn, rm;
      logic [W-1:0] imm;
      logic [1:0]   alu;
      logic [7:0]   ctl;
      int           fw, mw;
      logic [W-1:0] epc;
      logic [3:0]   efl;
      int           ecyc;
      logic [W-1:0] ew;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst8 = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         mem_req, mem_we, mem_ready, busy;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata, instr, imm_ext, pc;
   logic [3:0]   rd_addr, rn_addr, rm_addr, flags;
   logic [1:0]   alu_control;
   logic         alu_src, mov_src, cond_pass, set_flags, is_load, is_store, is_branch, reg_write;
   logic [2:0]   state;

   logic         m8_req, m8_we, busy8;
   logic [7:0]   m8_addr, m8_wdata, instr8, pc8, imm8;
   logic [3:0]   flags8;
   logic [2:0]   state8;

   multicycle_data_path dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
      .rd_addr(rd_addr), .rn_addr(rn_addr), .rm_addr(rm_addr), .imm_ext(imm_ext),
      .alu_control(alu_control), .alu_src(alu_src), .mov_src(mov_src), .cond_pass(cond_pass),
      .set_flags(set_flags), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
      .reg_write(reg_write), .pc(pc), .flags(flags), .state(state), .busy(busy)
   );

   multicycle_data_path #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .mem_req(m8_req), .mem_we(m8_we), .mem_addr(m8_addr),
      .mem_wdata(m8_wdata), .mem_rdata(8'h00), .mem_ready(1'b1), .instr(instr8),
      .rd_addr(rd_addr), .rn_addr(rn_addr), .rm_addr(rm_addr), .imm_ext(imm8),
      .alu_control(alu_control), .alu_src(alu_src), .mov_src(mov_src), .cond_pass(cond_pass),
      .set_flags(set_flags), .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
      .reg_write(reg_write), .pc(pc8), .flags(flags8), .state(state8), .busy(busy8)
   );

   // memory model with programmable wait states
   logic [W-1:0] mem [256];
   int  fwait = 0, mwait = 0, wcnt = 0;
   bit  hold = 1'b0;
   always @(negedge clk) begin
      #1;
      if (rst || !mem_req) begin
         mem_ready = 1'b0;
         wcnt = 0;
      end else if (hold) begin
         mem_ready = 1'b0;
      end else if (wcnt >= ((state == 3'd3) ? mwait : fwait)) begin
         if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
         mem_rdata = mem[mem_addr[7:0]];
         mem_ready = 1'b1;
         wcnt = 0;
      end else begin
         mem_ready = 1'b0;
         wcnt++;
      end
   end

   // scoreboard
   int n_cmp = 0, n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_fetch = '0;
   vec_t vecs[28];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                               input logic [W-1:0] imm, input logic [1:0] alu, input logic [7:0] ctl,
                               input int fw, input int mw, input logic [W-1:0] epc,
                               input logic [3:0] efl, input int ecyc, input logic [W-1:0] ew);
      vec_t v;
      v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm; v.alu = alu; v.ctl = ctl;
      v.fw = fw; v.mw = mw; v.epc = epc; v.efl = efl; v.ecyc = ecyc; v.ew = ew;
      return v;
   endfunction

   // driver
   task automatic drive_dec(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                            input logic [W-1:0] imm, input logic [1:0] alu, input logic [7:0] ctl);
      rd_addr = rd; rn_addr = rn; rm_addr = rm; imm_ext = imm; imm8 = imm[7:0];
      alu_control = alu;
      {alu_src, mov_src, cond_pass, set_flags, is_load, is_store, is_branch, reg_write} = ctl;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   start, n;
      bit   left, seen;
      logic [W-1:0] fetched;
      v = vecs[idx];
      fetched = exp_fetch;
      fwait = v.fw;
      mwait = v.mw;
      n = 0;
      while (!(state == 3'd0 && mem_req) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail_now($sformatf("v%0d fetch_req", idx));
      drive_dec(v.rd, v.rn, v.rm, v.imm, v.alu, v.ctl);
      if (v.ctl[2]) exp_q.push_back(v.ew);
      start = cyc;
      left = 1'b0;
      seen = 1'b0;
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (state == 3'd3) begin
            chk($sformatf("v%0d mem_addr", idx), mem_addr, v.imm);
            chk($sformatf("v%0d mem_we", idx), W'(mem_we), W'(v.ctl[2]));
            if (v.ctl[2] && mem_we) begin
               chk($sformatf("v%0d mem_wdata", idx), mem_wdata, exp_q[0]);
               seen = 1'b1;
            end
         end
         if (state != 3'd0) left = 1'b1;
         else if (left) break;
      end
      if (!(left && state == 3'd0)) fail_now($sformatf("v%0d return_to_fetch", idx));
      if (v.ctl[2]) begin
         if (!seen) fail_now($sformatf("v%0d store_access", idx));
         void'(exp_q.pop_front());
      end
      chk($sformatf("v%0d cycles", idx), W'(cyc - start), W'(v.ecyc));
      chk($sformatf("v%0d pc", idx), pc, v.epc);
      chk($sformatf("v%0d flags", idx), W'(flags), W'(v.efl));
      chk($sformatf("v%0d instr", idx), instr, W'(22'h100000) | fetched);
      chk($sformatf("v%0d next_fetch_addr", idx), mem_addr, v.epc);
      exp_fetch = v.epc;
   endtask

   task automatic run8(input logic [3:0] rd, input logic [3:0] rn, input logic [7:0] imm,
                       input logic [7:0] ctl, output logic [7:0] wd);
      int n;
      bit left;
      wd = '0;
      n = 0;
      while (!(state8 == 3'd0 && m8_req) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) fail_now("w8 fetch_req");
      drive_dec(rd, rn, 4'd0, W'(imm), ADD, ctl);
      left = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (state8 == 3'd3) wd = m8_wdata;
         if (state8 != 3'd0) left = 1'b1;
         else if (left) break;
      end
      if (!(left && state8 == 3'd0)) fail_now("w8 return_to_fetch");
   endtask

   logic [7:0] wd8;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = W'(22'h100000) | W'(i);
      mem_ready = 1'b0;
      mem_rdata = '0;
      drive_dec(4'd0, 4'd0, 4'd0, '0, ADD, 8'h00);

      vecs[0]  = mk(1, 0, 0, 5,          ADD,    ASRC|COND|SETF|RW, 3, 0, 4,  4'b0000, 7, 0);
      vecs[1]  = mk(2, 1, 0, 5,          SUB,    ASRC|COND|SETF|RW, 0, 0, 8,  4'b0110, 4, 0);
      vecs[2]  = mk(1, 0, 0, 99,         ADD,    ASRC|SETF|RW,      0, 0, 12, 4'b0110, 2, 0);
      vecs[3]  = mk(4, 1, 0, 'h0A,       ORR,    ASRC|COND|RW,      0, 0, 16, 4'b0110, 4, 0);
      vecs[4]  = mk(5, 4, 0, 3,          AND_OP, ASRC|COND|SETF|RW, 0, 0, 20, 4'b0010, 4, 0);
      vecs[5]  = mk(6, 0, 0, 1,          SUB,    ASRC|COND|SETF|RW, 0, 0, 24, 4'b1000, 4, 0);
      vecs[6]  = mk(7, 6, 6, 0,          ADD,    COND|SETF|RW,      1, 0, 28, 4'b1010, 5, 0);
      vecs[7]  = mk(8, 6, 0, 'h1FFFFF,   ADD,    ASRC|MOV|COND|RW,  0, 0, 32, 4'b1010, 4, 0);
      vecs[8]  = mk(9, 8, 0, 1,          ADD,    ASRC|COND|SETF|RW, 0, 0, 36, 4'b1001, 4, 0);
      vecs[9]  = mk(1, 0, 0, 'h90,       ADD,    STO,               0, 2, 40, 4'b1001, 6, 5);
      vecs[10] = mk(3, 0, 0, 'h90,       ADD,    LDO,               0, 2, 44, 4'b1001, 7, 0);
      vecs[11] = mk(3, 0, 0, 'h94,       ADD,    STO,               0, 0, 48, 4'b1001, 4, 5);
      vecs[12] = mk(2, 0, 0, 'h98,       ADD,    STO,               0, 0, 52, 4'b1001, 4, 0);
      vecs[13] = mk(4, 0, 0, 'h98,       ADD,    STO,               0, 0, 56, 4'b1001, 4, 'hF);
      vecs[14] = mk(5, 0, 0, 'h98,       ADD,    STO,               0, 0, 60, 4'b1001, 4, 3);
      vecs[15] = mk(6, 0, 0, 'h98,       ADD,    STO,               0, 0, 64, 4'b1001, 4, 'h3FFFFF);
      vecs[16] = mk(7, 0, 0, 'h98,       ADD,    STO,               0, 0, 68, 4'b1001, 4, 'h3FFFFE);
      vecs[17] = mk(8, 0, 0, 'h98,       ADD,    STO,               0, 0, 72, 4'b1001, 4, 'h1FFFFF);
      vecs[18] = mk(9, 0, 0, 'h98,       ADD,    STO,               0, 0, 76, 4'b1001, 4, 'h200000);
      vecs[19] = mk(15, 0, 0, 'h9C,      ADD,    STO,               0, 0, 80, 4'b1001, 4, 84);
      vecs[20] = mk(1, 0, 0, 7,          ADD,    ASRC|RW,           0, 0, 4,  4'b0000, 2, 0);
      vecs[21] = mk(2, 0, 0, 7,          SUB,    ASRC|SETF|RW,      0, 0, 8,  4'b0000, 2, 0);
      vecs[22] = mk(0, 15, 0, 8,         ADD,    ASRC|COND|BR,      0, 0, 24, 4'b0000, 3, 0);
      vecs[23] = mk(15, 0, 0, 0,         ADD,    ASRC|MOV|COND|RW,  0, 0, 0,  4'b0000, 4, 0);
      vecs[24] = mk(15, 0, 0, 'hA0,      ADD,    STO,               0, 0, 4,  4'b0000, 4, 8);
      vecs[25] = mk(1, 0, 0, 'hA4,       ADD,    STO,               0, 0, 8,  4'b0000, 4, 0);
      vecs[26] = mk(3, 0, 0, 'hA0,       ADD,    LDO,               0, 0, 12, 4'b0000, 5, 0);
      vecs[27] = mk(3, 0, 0, 'hA8,       ADD,    STO,               0, 0, 16, 4'b0000, 4, 8);

      repeat (2) @(negedge clk);
      chk("reset pc", pc, '0);
      chk("reset state", W'(state), '0);
      chk("reset mem_req", W'(mem_req), '0);
      chk("reset flags", W'(flags), '0);
      chk("reset instr", instr, '0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) run_vec(i);

      // reset while a fetch is stalled on mem_ready
      hold = 1'b1;
      repeat (3) @(negedge clk);
      chk("stall state", W'(state), '0);
      chk("stall mem_req", W'(mem_req), W'(1'b1));
      chk("stall pc", pc, W'(80));
      #2 rst = 1'b1;
      #1;
      chk("async reset pc", pc, '0);
      chk("async reset state", W'(state), '0);
      chk("async reset mem_req", W'(mem_req), '0);
      @(negedge clk);
      rst = 1'b0;
      hold = 1'b0;
      fwait = 0;
      exp_fetch = '0;
      #1;
      chk("post reset busy", W'(busy), '0);
      chk("post reset idle req", W'(mem_req), '0);
      @(negedge clk);
      chk("first req", W'(mem_req), W'(1'b1));
      chk("first req addr", mem_addr, '0);
      chk("first req busy", W'(busy), W'(1'b1));

      for (int i = 20; i < 28; i++) run_vec(i);

      // 8-bit instance: 0x7F + 1 overflows into the sign bit
      rst = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      run8(4'd1, 4'd0, 8'h7F, ASRC|MOV|COND|RW, wd8);
      run8(4'd2, 4'd1, 8'h01, ASRC|COND|SETF|RW, wd8);
      chk("w8 flags", W'(flags8), W'(4'b1001));
      chk("w8 pc", W'(pc8), W'(8));
      run8(4'd2, 4'd0, 8'h40, STO, wd8);
      chk("w8 result", W'(wd8), W'(8'h80));
      chk("w8 pc after store", W'(pc8), W'(12));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_data_path.md
Name: multicycle_data_path

Overview:
- Parametrised, multi-cycle successor to the single-cycle 22-bit datapath.
- Fetches, decodes, executes, accesses memory and writes back over several cycles through one shared memory port with a req/ready handshake.
- Exports the instruction register to an external combinational decoder. The decoder returns control, register addresses and the extended immediate.
- Keeps architectural state: PC, register file (top register reads as PC+8), and NZCV flags with optional update.

Parameters:
WIDTH, 22, datapath/address/data width in bits
REG_COUNT, 16, number of architectural registers; index REG_COUNT-1 is the PC alias
REG_ADDR_W, 4, register address width; must equal clog2(REG_COUNT)
PC_STEP, 4, PC increment per instruction
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  WIDTH  memory address
mem_wdata  output  WIDTH  store data
mem_rdata  input  WIDTH  read data; valid when mem_ready=1
mem_ready  input  1  access completes this cycle
instr  output  WIDTH  instruction register contents, to the decoder
rd_addr, rn_addr, rm_addr  input  REG_ADDR_W each  destination and source registers
imm_ext  input  WIDTH  extended immediate
alu_control  input  2  00 add, 01 sub, 10 and, 11 orr
alu_src  input  1  0 = rm, 1 = imm_ext as operand B
mov_src  input  1  1 = operand A forced to 0
cond_pass  input  1  0 = instruction squashed
set_flags  input  1  update NZCV in EXEC
is_load, is_store, is_branch, reg_write  input  1 each  instruction class
pc  output  WIDTH  current PC
flags  output  4  NZCV
state  output  3  FSM state, for debug/verification
busy  output  1  high in every state except FETCH before a request is issued

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC, all registers 0, flags=0, instr=0, state=FETCH, mem_req=0. Reset mid-access abandons the transaction immediately.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=pc.
  - Hold until mem_ready. On the ready cycle: instr<=mem_rdata, pc<=pc+PC_STEP, go to DECODE.
- DECODE:
  - Latch A<=reg[rn_addr] and B<=reg[rm_addr] (or imm_ext per alu_src). Reading index REG_COUNT-1 returns fetched address+2*PC_STEP.
  - If cond_pass=0, go to FETCH with no state change.
  - Otherwise go to EXEC.
- EXEC:
  - ALU result R is latched. If mov_src=1, A is treated as 0.
  - Add: C = carry out of the MSB.
  - Sub: computed as A+~B+1; C = carry out (1 = no borrow).
  - V is signed overflow for add/sub. C and V are left unchanged for and/orr.
  - N=R[WIDTH-1], Z=(R==0).
  - Flags are written only if set_flags=1.
  - Next state: is_branch → pc<=R, then FETCH. is_load or is_store → MEM. reg_write → WB. Otherwise FETCH.
- MEM:
  - mem_req=1, mem_addr=R, mem_we=is_store, mem_wdata=reg[rd_addr].
  - Address and data stay stable until mem_ready.
  - Load → WB with data latched. Store → FETCH.
- WB:
  - reg[rd_addr] <= load data or R.
  - A write to REG_COUNT-1 also sets pc to that value, then FETCH.
- Widths: all arithmetic is modulo 2^WIDTH; PC wraps silently.
- mem_req drops in the cycle after a mem_ready. Back-to-back requests have at least one idle cycle except FETCH following MEM/WB.
- Decoder inputs are sampled only in DECODE/EXEC/MEM/WB of the current instruction. They may change in FETCH.
- Minimum CPI with zero-wait memory:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store or branch: 4 or 3 cycles, respectively.
  - Squashed instruction: 2 cycles.

Test Plan:
- Reset during FETCH wait with mem_ready held 0 → pc=0, state=0, mem_req=0 in the same cycle as rst rises; after release, first request has mem_addr=0.
- add r1, r0(=0), imm 5 with set_flags=1, 3 wait states on fetch → r1=5, flags=0000, pc=4, FETCH re-entered exactly 4+3 cycles after first req.
- sub r2, r1(=5), imm 5 with set_flags=1 → r2=0, flags N=0 Z=1 C=1 V=0. Repeat with WIDTH=8: 0x7F add 1 → R=0x80, N=1, V=1.
- Store r1(=5) at address 0x10, then load r3 from 0x10 with 2-cycle ready delay → mem_wdata=5 held stable through the wait; r3=5.
- cond_pass=0 on a reg_write instruction → destination unchanged, flags unchanged, pc advanced by 4, 2 cycles total.
- Branch: PC=8, operand A is r15 (reads 16), imm=8 → pc=24; next fetch mem_addr=24. Separately, WB to r15 with value 0 → next fetch at 0.
